// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop, no
//            parity). Synchronises the asynchronous serial line into the clk
//            domain, samples each bit at its centre and holds the last good
//            byte on RxData until the next good frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous active-low reset (0 = reset)
//   RxD       in   1  serial input, idle high, asynchronous to clk
//   RxData    out  8  last correctly received byte
//   RxValid   out  1  one-clock pulse when RxData is updated
//   FrameErr  out  1  one-clock pulse when the stop bit is sampled low
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       FrameErr
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = 14;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             sync_meta, rxs;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             shift_en, load_en, err_en, cnt_clr;

  // Two-flop synchroniser; resets to the idle (high) line level so a
  // reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync_meta <= RxD;
      rxs       <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    err_en    = 1'b0;
    case (state)
      S_IDLE:  if (!rxs) state_nxt = S_START;
      S_START: begin
        // Re-check the line at the start-bit centre; a high here was a glitch.
        if (bit_cnt == HALF_LAST) state_nxt = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          if (rxs) begin
            load_en   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_en    = 1'b1;
            state_nxt = S_BRK;
          end
        end
      end
      // A line held low after a bad stop bit must not be taken as a new start.
      S_BRK:   if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The bit-timing counter restarts on every state change and at every
  // data-bit centre; it is held at zero while waiting on the line.
  assign cnt_clr = (state_nxt != state) || shift_en ||
                   (state == S_IDLE) || (state == S_BRK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      RxData    <= 8'h00;
      RxValid   <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      bit_cnt  <= cnt_clr ? '0 : bit_cnt + CNT_W'(1);
      RxValid  <= load_en;
      FrameErr <= err_en;
      if (state == S_START && state_nxt == S_DATA) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx            <= bit_idx + 3'd1;
        shift_reg[bit_idx] <= rxs;
      end
      // RxData only ever takes a completed, correctly framed byte.
      if (load_en) RxData <= shift_reg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver. Runs the receiver at a
//            scaled baud rate (16 clocks per bit) and drives serial frames
//            from the bench; a frame-level model tracks expected bytes,
//            frame errors and the held RxData value.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int BAUD_RATE   = 6_250_000;
  localparam int CLK_NS      = 10;
  localparam int BIT_NS      = 1_000_000_000 / BAUD_RATE;   // 160 ns

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       RxD   = 1'b1;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FrameErr;

  uart_receiver #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .RxD     (RxD),
    .RxData  (RxData),
    .RxValid (RxValid),
    .FrameErr(FrameErr)
  );

  always #(CLK_NS / 2) clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observed events, collected away from the active edge.
  logic [7:0] got_q[$];
  time        got_t[$];
  int         ferr_seen = 0;
  int         stray     = 0;
  logic [7:0] prev_data = 8'h00;

  // Frame-level reference model.
  logic [7:0] model_data = 8'h00;
  int         model_ferr = 0;
  int         model_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_data = 8'h00;
      end else begin
        if (RxValid) begin
          got_q.push_back(RxData);
          got_t.push_back($time);
        end else if (RxData !== prev_data) begin
          stray++;
        end
        prev_data = RxData;
        if (FrameErr === 1'b1) ferr_seen++;
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives start, 8 data bits LSB first and the stop bit at the given level;
  // leaves the line at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int bit_ns);
    RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      #(bit_ns);
    end
    RxD = stop_lvl;
    #(bit_ns);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    #(n * BIT_NS);
  endtask

  task automatic model_good(input logic [7:0] b);
    model_data = b;
    model_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    RxD   = 1'b1;
    #100;
    total_cnt++;
    if (RxData !== 8'h00) $display("FAIL reset_rxdata: got %h want 00", RxData);
    else pass_cnt++;
    total_cnt++;
    if (RxValid !== 1'b0 || FrameErr !== 1'b0)
      $display("FAIL reset_pulses: got valid=%b ferr=%b want 0/0", RxValid, FrameErr);
    else pass_cnt++;
    reset = 1'b1;
    idle_bits(40);
    total_cnt++;
    if (got_q.size() != 0 || ferr_seen != 0)
      $display("FAIL idle_no_events: got valid=%0d ferr=%0d want 0/0", got_q.size(), ferr_seen);
    else pass_cnt++;
    total_cnt++;
    if (RxData !== 8'h00) $display("FAIL idle_rxdata: got %h want 00", RxData);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int  n0;
    time t_stop;
    time lat;
    n0     = got_q.size();
    t_stop = $time + time'(9 * BIT_NS);
    send_frame(8'h9D, 1'b1, BIT_NS);
    model_good(8'h9D);
    idle_bits(2);
    total_cnt++;
    if (got_q.size() != n0 + 1)
      $display("FAIL single_count: got %0d pulses want 1", got_q.size() - n0);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() <= n0) begin
      $display("FAIL single_byte: got none want %h", model_data);
    end else if (got_q[n0] !== model_data) begin
      $display("FAIL single_byte: got %h want %h", got_q[n0], model_data);
    end else pass_cnt++;
    // Pulse expected about half a bit into the stop bit, plus sync/register delay.
    total_cnt++;
    if (got_q.size() <= n0) begin
      $display("FAIL single_latency: no pulse seen");
    end else begin
      lat = got_t[n0] - t_stop;
      if (lat < time'(BIT_NS / 2) || lat > time'(BIT_NS / 2 + 5 * CLK_NS))
        $display("FAIL single_latency: got %0d ns want %0d..%0d ns",
                 lat, BIT_NS / 2, BIT_NS / 2 + 5 * CLK_NS);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = got_q.size();
    send_frame(8'h55, 1'b1, BIT_NS);
    send_frame(8'hA3, 1'b1, BIT_NS);
    model_good(8'h55);
    model_good(8'hA3);
    idle_bits(2);
    total_cnt++;
    if (got_q.size() != n0 + 2) begin
      $display("FAIL b2b_count: got %0d pulses want 2", got_q.size() - n0);
    end else begin
      pass_cnt++;
      total_cnt++;
      if (got_q[n0] !== 8'h55 || got_q[n0+1] !== 8'hA3)
        $display("FAIL b2b_bytes: got %h,%h want 55,a3", got_q[n0], got_q[n0+1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (RxData !== model_data) $display("FAIL b2b_rxdata: got %h want %h", RxData, model_data);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = got_q.size();
    f0 = ferr_seen;
    RxD = 1'b0; #20; idle_bits(3);
    RxD = 1'b0; #50; idle_bits(3);
    total_cnt++;
    if (got_q.size() != n0 || ferr_seen != f0)
      $display("FAIL glitch_events: got valid=%0d ferr=%0d want 0/0", got_q.size() - n0, ferr_seen - f0);
    else pass_cnt++;
    total_cnt++;
    if (RxData !== model_data) $display("FAIL glitch_rxdata: got %h want %h", RxData, model_data);
    else pass_cnt++;
  endtask

  task automatic test_frame_error;
    int n0, f0;
    n0 = got_q.size();
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(2 * BIT_NS);               // line held low three bit times in total
    model_ferr++;
    idle_bits(2);
    total_cnt++;
    if (ferr_seen != f0 + 1) $display("FAIL ferr_count: got %0d want 1", ferr_seen - f0);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() != n0) $display("FAIL ferr_no_valid: got %0d pulses want 0", got_q.size() - n0);
    else pass_cnt++;
    total_cnt++;
    if (RxData !== model_data) $display("FAIL ferr_rxdata_held: got %h want %h", RxData, model_data);
    else pass_cnt++;
    send_frame(8'h12, 1'b1, BIT_NS);
    model_good(8'h12);
    idle_bits(2);
    total_cnt++;
    if (RxData !== 8'h12 || got_q.size() != n0 + 1)
      $display("FAIL ferr_recover: got %h pulses=%0d want 12 pulses=1", RxData, got_q.size() - n0);
    else pass_cnt++;
    total_cnt++;
    if (ferr_seen != f0 + 1) $display("FAIL ferr_once: got %0d want 1", ferr_seen - f0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int         n0;
    logic [7:0] b;
    n0 = got_q.size();
    b  = 8'h5A;
    RxD = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      #(BIT_NS);
    end
    RxD = b[4];
    #(BIT_NS / 3);
    @(negedge clk);
    reset = 1'b0;
    model_data = 8'h00;
    #1;
    total_cnt++;
    if (RxData !== 8'h00 || RxValid !== 1'b0 || FrameErr !== 1'b0)
      $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", RxData, RxValid, FrameErr);
    else pass_cnt++;
    RxD = 1'b1;
    #100;
    reset = 1'b1;
    idle_bits(3);
    total_cnt++;
    if (got_q.size() != n0 || RxData !== 8'h00)
      $display("FAIL midreset_discard: got %h pulses=%0d want 00 pulses=0", RxData, got_q.size() - n0);
    else pass_cnt++;
    send_frame(8'hF0, 1'b1, BIT_NS);
    model_good(8'hF0);
    idle_bits(2);
    total_cnt++;
    if (got_q.size() != n0 + 1 || RxData !== 8'hF0)
      $display("FAIL midreset_next: got %h pulses=%0d want f0 pulses=1", RxData, got_q.size() - n0);
    else pass_cnt++;
  endtask

  // Random bytes, slightly mismatched baud, random gaps and occasional bad stop bits.
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         n0, f0, bn;
    bit         bad;
    n0 = got_q.size();
    f0 = ferr_seen;
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom);
      bn  = int'($urandom_range(157, 163));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, bn);
      if (bad) begin
        #(int'($urandom_range(0, 2)) * bn);
        RxD = 1'b1;
        #(bn);
        model_ferr++;
      end else begin
        exp_q.push_back(b);
        model_good(b);
      end
      RxD = 1'b1;
      #(int'($urandom_range(0, 2)) * bn);
    end
    idle_bits(3);
    total_cnt++;
    if (got_q.size() - n0 != exp_q.size())
      $display("FAIL rand_count: got %0d bytes want %0d", got_q.size() - n0, exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[n0+i] !== exp_q[i])
        $display("FAIL rand_byte%0d: got %h want %h", i, got_q[n0+i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (ferr_seen != model_ferr)
      $display("FAIL rand_ferr: got %0d want %0d", ferr_seen, model_ferr);
    else pass_cnt++;
    total_cnt++;
    if (RxData !== model_data) $display("FAIL rand_rxdata: got %h want %h", RxData, model_data);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() != model_cnt) $display("FAIL total_valid: got %0d want %0d", got_q.size(), model_cnt);
    else pass_cnt++;
    total_cnt++;
    if (stray != 0) $display("FAIL rxdata_stable: got %0d unflagged changes want 0", stray);
    else pass_cnt++;
    if (ferr_seen - f0 < 0) $display("note: frame error counter went backwards");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
